multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, maximum wait cycles for imem_ready/dmem_ready before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag; sampled in EXEC for branches.
REQ-006 imem_ready  input  1  instruction memory accepted fetch; instruction valid this cycle.
REQ-007 dmem_ready  input  1  data memory completed read/write this cycle.
REQ-008 imem_req  output  1  fetch request, held high for the whole FETCH state.
REQ-009 ir_write  output  1  one-cycle pulse; instruction register loads.
REQ-010 ALUSrc  output  1  0 = ReadData2, 1 = imm32 as ALU operand 2.
REQ-011 ALUOp  output  2  00 add, 01 subtract, 10 funct-decoded; 11 never driven.
REQ-012 MemRead / MemWrite  output  1 each  data memory request, held for the whole MEM state.
REQ-013 MemtoReg  output  1  1 = writeback data from memory, 0 = from ALUResult.
REQ-014 RegWrite  output  1  one-cycle register-file write pulse.
REQ-015 PCWrite  output  1  one-cycle PC update pulse; PCSrc  output  1  0 = PC+4, 1 = branch/jump target.
REQ-016 bus_err  output  1  sticky; set on memory timeout.
REQ-017 illegal  output  1  sticky; set on unsupported opcode.
REQ-018 state  output  3  current FSM state encoding, for debug.

Function
REQ-019 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; all other encodings go to FETCH on the next edge.
REQ-020 FETCH: assert imem_req; on imem_ready, pulse ir_write in the same cycle and go to DECODE.
REQ-021 DECODE: one cycle; a supported opcode goes to EXEC; any other opcode sets illegal and goes to HALT.
REQ-022 Supported opcodes: R 0110011, I-arith 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111.
REQ-023 EXEC outputs, all opcodes:
- R-type: ALUSrc=0, ALUOp=10.
- I-arith: ALUSrc=1, ALUOp=10.
- load/store: ALUSrc=1, ALUOp=00.
- branch: ALUSrc=0, ALUOp=01.
- jal: ALUSrc=1, ALUOp=00.
REQ-024 EXEC next state: R, I-arith -> WB; load, store -> MEM; branch, jal -> FETCH.
REQ-025 Branch in EXEC: pulse PCWrite with PCSrc=zero.
REQ-026 jal in EXEC: pulse PCWrite with PCSrc=1 and pulse RegWrite with MemtoReg=0.
REQ-027 MEM: load asserts MemRead, store asserts MemWrite; both stay asserted until dmem_ready.
REQ-028 On dmem_ready in MEM: load -> WB; store pulses PCWrite (PCSrc=0) and goes to FETCH.
REQ-029 WB: one cycle; pulse RegWrite and PCWrite (PCSrc=0); MemtoReg=1 for load, 0 otherwise; then FETCH.
REQ-030 Outputs are decoded from registered state and the latched opcode only; outputs not named for a state SHALL be 0.
REQ-031 Wait counter: clears on entry to FETCH or MEM, increments every cycle the ready is low, saturates at TIMEOUT_CYCLES.
REQ-032 Timeout: counter == TIMEOUT_CYCLES with ready still low sets bus_err and goes to HALT; ready arriving on the same cycle wins (normal progress, no error).
REQ-033 HALT: all strobes 0; the state persists until reset.
REQ-034 Exactly one PCWrite pulse per retired instruction; none for illegal or aborted instructions.

Reset
REQ-035 Asserting rst_n low at any time, including mid-MEM, forces state=FETCH immediately.
REQ-036 During reset all outputs are 0, the counter is 0, and bus_err and illegal are cleared.
REQ-037 First imem_req is in the first cycle after rst_n deassertion.

Structure
REQ-038 Shared package holds: state encodings, opcode constants, ALUOp encodings (ADD=00, SUB=01, FUNCT=10), and the TIMEOUT_CYCLES default.
REQ-039 Single module, no sub-modules; the wait counter is inline.

Verification
REQ-040 R-type: imem_ready on cycle 1 -> ir_write@1, EXEC ALUOp=10 ALUSrc=0, RegWrite and PCWrite pulse in WB, 4 cycles total.
REQ-041 Load with dmem_ready after 3 wait cycles -> MemRead high for 4 cycles, then WB with MemtoReg=1 and RegWrite=1.
REQ-042 Branch with zero=1 -> PCWrite=1, PCSrc=1, ALUOp=01 in EXEC, no RegWrite; with zero=0 -> PCSrc=0.
REQ-043 Opcode 1111111 -> illegal=1, state=HALT, no RegWrite or PCWrite ever asserted.
REQ-044 Store with dmem_ready never asserted, TIMEOUT_CYCLES=4 -> bus_err=1 and HALT after 4 wait cycles; ready arriving on cycle 4 -> no error.
REQ-045 rst_n pulsed low mid-MEM -> MemWrite drops asynchronously, state=0, imem_req high on the first cycle after release.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
//  Module      : multicycle_ctrl_pkg
//  Description : Shared encodings for the multicycle datapath controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 15;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic opcode_supported(input logic [6:0] opc);
        logic ok;
        ok = 1'b0;
        case (opc)
            OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL: ok = 1'b1;
            default:                                                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multicycle CPU control FSM with memory-ready timeout abort.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_write,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       PCSrc,
    output logic       bus_err,
    output logic       illegal,
    output logic [2:0] state
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [6:0]       opc_q,     opc_d;
    logic             bus_err_q, bus_err_d;
    logic             illegal_q, illegal_d;
    logic             w_timeout;

    assign w_timeout = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            opc_q     <= '0;
            bus_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opc_q     <= opc_d;
            bus_err_q <= bus_err_d;
            illegal_q <= illegal_d;
        end
    end

    // The wait counter is zeroed on every transition into FETCH or MEM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        opc_d     = opc_q;
        bus_err_d = bus_err_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (w_timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                opc_d = opcode;
                if (opcode_supported(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end
            end
            ST_EXEC: begin
                cnt_d = '0;
                case (opc_q)
                    OPC_R, OPC_I:         state_d = ST_WB;
                    OPC_LOAD, OPC_STORE:  state_d = ST_MEM;
                    default:              state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (opc_q == OPC_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        cnt_d   = '0;
                    end
                end else if (w_timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                cnt_d   = '0;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALUOP_ADD;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                ST_EXEC: begin
                    case (opc_q)
                        OPC_R: begin
                            ALUOp = ALUOP_FUNCT;
                        end
                        OPC_I: begin
                            ALUSrc = 1'b1;
                            ALUOp  = ALUOP_FUNCT;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            ALUSrc = 1'b1;
                        end
                        OPC_BRANCH: begin
                            ALUOp   = ALUOP_SUB;
                            PCWrite = 1'b1;
                            PCSrc   = zero;
                        end
                        OPC_JAL: begin
                            ALUSrc   = 1'b1;
                            PCWrite  = 1'b1;
                            PCSrc    = 1'b1;
                            RegWrite = 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    MemRead  = (opc_q == OPC_LOAD);
                    MemWrite = (opc_q == OPC_STORE);
                    PCWrite  = (opc_q == OPC_STORE) && dmem_ready;
                end
                ST_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    MemtoReg = (opc_q == OPC_LOAD);
                end
                default: ;
            endcase
        end
    end

    assign bus_err = bus_err_q;
    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Trace-model bench for multicycle_ctrl (TIMEOUT_CYCLES = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int TMO = 4;

    localparam logic [6:0] R_T  = 7'b0110011;
    localparam logic [6:0] I_T  = 7'b0010011;
    localparam logic [6:0] LD_T = 7'b0000011;
    localparam logic [6:0] ST_T = 7'b0100011;
    localparam logic [6:0] BR_T = 7'b1100011;
    localparam logic [6:0] JL_T = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       imem_req, ir_write, ALUSrc, MemRead, MemWrite, MemtoReg;
    logic       RegWrite, PCWrite, PCSrc, bus_err, illegal;
    logic [1:0] ALUOp;
    logic [2:0] state;

    typedef struct packed {
        logic       imem_req, ir_write, alusrc;
        logic [1:0] aluop;
        logic       memread, memwrite, memtoreg, regwrite, pcwrite, pcsrc, bus_err, illegal;
        logic [2:0] state;
    } outs_t;

    typedef struct {
        string      tag;
        logic       im, dm, z;
        logic [6:0] opc;
        outs_t      o;
    } step_t;

    step_t plan[$];
    outs_t cur_exp;
    outs_t act;
    string cur_tag;
    bit    exp_valid = 1'b0;
    int    checks = 0;
    int    failures = 0;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .bus_err(bus_err), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {imem_req, ir_write, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg,
                  RegWrite, PCWrite, PCSrc, bus_err, illegal, state};

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) check({"cyc_", cur_tag}, act, cur_exp);
    end

    function automatic outs_t st(input logic [2:0] s);
        outs_t o;
        o = '0;
        o.state = s;
        return o;
    endfunction

    task automatic push(input string tag, input logic im, input logic dm, input logic z,
                        input logic [6:0] opc, input outs_t o);
        step_t s;
        s.tag = tag; s.im = im; s.dm = dm; s.z = z; s.opc = opc; s.o = o;
        plan.push_back(s);
    endtask

    // HALT ignores ready inputs, so they are driven high to expose stray strobes.
    task automatic add_halt(input string tag, input logic be, input logic il,
                            input logic [6:0] opc, input int n);
        outs_t o;
        for (int i = 0; i < n; i++) begin
            o = st(3'd5);
            o.bus_err = be;
            o.illegal = il;
            push(tag, 1'b1, 1'b1, 1'b0, opc, o);
        end
    endtask

    // fw/mw: ready-low cycles before ready; a value above TMO means ready never comes.
    task automatic add_instr(input string tag, input logic [6:0] opc, input int fw,
                             input int mw, input logic z);
        outs_t o;
        int    nlow;
        logic  is_ld, is_st;
        is_ld = (opc == LD_T);
        is_st = (opc == ST_T);
        nlow = (fw > TMO) ? TMO + 1 : fw;
        for (int k = 0; k < nlow; k++) begin
            o = st(3'd0); o.imem_req = 1'b1;
            push(tag, 1'b0, 1'b0, z, opc, o);
        end
        if (fw > TMO) begin
            add_halt(tag, 1'b1, 1'b0, opc, 3);
            return;
        end
        o = st(3'd0); o.imem_req = 1'b1; o.ir_write = 1'b1;
        push(tag, 1'b1, 1'b0, z, opc, o);
        o = st(3'd1);
        push(tag, 1'b0, 1'b0, z, opc, o);
        if (!(opc inside {R_T, I_T, LD_T, ST_T, BR_T, JL_T})) begin
            add_halt(tag, 1'b0, 1'b1, opc, 3);
            return;
        end
        o = st(3'd2);
        case (opc)
            R_T:       begin o.alusrc = 1'b0; o.aluop = 2'b10; end
            I_T:       begin o.alusrc = 1'b1; o.aluop = 2'b10; end
            LD_T, ST_T: begin o.alusrc = 1'b1; o.aluop = 2'b00; end
            BR_T:      begin o.alusrc = 1'b0; o.aluop = 2'b01; o.pcwrite = 1'b1; o.pcsrc = z; end
            default:   begin o.alusrc = 1'b1; o.aluop = 2'b00; o.pcwrite = 1'b1;
                             o.pcsrc = 1'b1; o.regwrite = 1'b1; end
        endcase
        push(tag, 1'b0, 1'b0, z, opc, o);
        if (opc == BR_T || opc == JL_T) return;
        if (is_ld || is_st) begin
            nlow = (mw > TMO) ? TMO + 1 : mw;
            for (int k = 0; k < nlow; k++) begin
                o = st(3'd3); o.memread = is_ld; o.memwrite = is_st;
                push(tag, 1'b0, 1'b0, z, opc, o);
            end
            if (mw > TMO) begin
                add_halt(tag, 1'b1, 1'b0, opc, 3);
                return;
            end
            o = st(3'd3); o.memread = is_ld; o.memwrite = is_st; o.pcwrite = is_st;
            push(tag, 1'b0, 1'b1, z, opc, o);
            if (is_st) return;
        end
        o = st(3'd4); o.regwrite = 1'b1; o.pcwrite = 1'b1; o.memtoreg = is_ld;
        push(tag, 1'b0, 1'b0, z, opc, o);
    endtask

    // Entered and left at one time unit after a rising edge.
    task automatic run_steps(input int n);
        step_t s;
        for (int i = 0; i < n && plan.size() > 0; i++) begin
            s = plan.pop_front();
            imem_ready = s.im; dmem_ready = s.dm; zero = s.z; opcode = s.opc;
            cur_exp = s.o; cur_tag = s.tag; exp_valid = 1'b1;
            @(posedge clk); #1;
        end
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        rst_n = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
        #1;
        check("reset_outs", act, 16'h0000);
        @(posedge clk); #1;
        check("reset_hold", act, 16'h0000);
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        int cnt;
        @(posedge clk); #1;
        do_reset();

        n0 = plan.size();
        add_instr("r", R_T, 0, 0, 1'b0);
        check("model_r_len", 16'(plan.size() - n0), 16'd4);
        add_instr("i_w2", I_T, 2, 0, 1'b0);
        n0 = plan.size();
        add_instr("ld_w3", LD_T, 1, 3, 1'b0);
        cnt = 0;
        for (int i = n0; i < plan.size(); i++) if (plan[i].o.memread) cnt++;
        check("model_ld_memread", 16'(cnt), 16'd4);
        check("model_ld_wb", 16'({plan[plan.size()-1].o.memtoreg, plan[plan.size()-1].o.regwrite}), 16'd3);
        add_instr("st", ST_T, 0, 0, 1'b0);
        n0 = plan.size();
        add_instr("br_z1", BR_T, 0, 0, 1'b1);
        check("model_br_exec", 16'({plan[plan.size()-1].o.pcwrite, plan[plan.size()-1].o.pcsrc,
                                    plan[plan.size()-1].o.aluop, plan[plan.size()-1].o.regwrite}), 16'b11010);
        add_instr("br_z0", BR_T, 0, 0, 1'b0);
        add_instr("jal", JL_T, 1, 0, 1'b0);
        add_instr("i_f4", I_T, TMO, 0, 1'b0);
        add_instr("ld_m4", LD_T, 0, TMO, 1'b0);
        add_instr("ill", BAD, 0, 0, 1'b0);
        run_steps(1000);

        do_reset();
        add_instr("st_tmo", ST_T, 0, 99, 1'b0);
        run_steps(1000);

        do_reset();
        add_instr("if_tmo", I_T, 99, 0, 1'b0);
        run_steps(1000);

        do_reset();
        add_instr("st_rst", ST_T, 0, 99, 1'b0);
        run_steps(5);
        plan.delete();
        check("midmem_pre", 16'(MemWrite), 16'd1);
        rst_n = 1'b0;
        #1;
        check("midmem_memwrite", 16'(MemWrite), 16'd0);
        check("midmem_state", 16'(state), 16'd0);
        do_reset();
        add_instr("r_after", R_T, 0, 0, 1'b0);
        run_steps(1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
